carregador_matriz: RTL and testbench

- Sequential loader that produces the flattened 5x5 8-bit matrix bus consumed by the coprocessor's combinational matrix operators, such as the negation unit.
- Accepts matrix elements one at a time over a valid/ready stream and places each at its flattened index.
- Presents the completed matrix with a valid/ack handshake.
- Supports square sizes 2..5. Positions outside the active size are zeroed.

---
 rtl/carregador_matriz_pkg.sv | 25 ++
 rtl/carregador_matriz_if.sv | 36 +++
 rtl/carregador_matriz_contador_indice.sv | 38 +++
 rtl/carregador_matriz.sv | 118 +++++++++++
 tb/tb_carregador_matriz.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/carregador_matriz_pkg.sv
// rtl/carregador_matriz_pkg.sv - shared constants, FSM states and flat-index helpers for the matrix loader
package carregador_matriz_pkg;

  localparam int LARGURA_ELEM = 8;
  localparam int DIM_MAX      = 5;
  localparam int MATRIZ_BITS  = LARGURA_ELEM * DIM_MAX * DIM_MAX;
  localparam int TAM_MIN      = 2;
  localparam int TAM_BITS     = 3;

  typedef enum logic [1:0] {
    OCIOSO  = 2'd0,
    CARREGA = 2'd1,
    PRONTA  = 2'd2
  } estado_t;

  // Same flattening the matrix operators use: linha is the fast index inside a coluna.
  function automatic int indice(input int coluna, input int linha);
    return LARGURA_ELEM * (linha + DIM_MAX * coluna);
  endfunction

  function automatic logic tamanho_legal(input logic [TAM_BITS-1:0] t);
    return (t >= TAM_BITS'(TAM_MIN)) && (t <= TAM_BITS'(DIM_MAX));
  endfunction

endpackage

// File: rtl/carregador_matriz_if.sv
// rtl/carregador_matriz_if.sv - element stream, matrix handshake and status bundle of the loader
// Carries negar only when CARREGADOR_NEGA_EN is defined.
interface carregador_matriz_if;
  import carregador_matriz_pkg::*;

  logic                    inicio;
  logic [TAM_BITS-1:0]     tamanho;
  logic [LARGURA_ELEM-1:0] elem_dado;
  logic                    elem_valido;
  logic                    elem_pronto;
  logic [MATRIZ_BITS-1:0]  matriz_saida;
  logic                    matriz_valida;
  logic                    matriz_ack;
  logic                    ocupado;
  logic                    erro_tamanho;
`ifdef CARREGADOR_NEGA_EN
  logic                    negar;
`endif

  modport master (
`ifdef CARREGADOR_NEGA_EN
    output negar,
`endif
    output inicio, tamanho, elem_dado, elem_valido, matriz_ack,
    input  elem_pronto, matriz_saida, matriz_valida, ocupado, erro_tamanho
  );

  modport slave (
`ifdef CARREGADOR_NEGA_EN
    input  negar,
`endif
    input  inicio, tamanho, elem_dado, elem_valido, matriz_ack,
    output elem_pronto, matriz_saida, matriz_valida, ocupado, erro_tamanho
  );

endinterface

// File: rtl/carregador_matriz_contador_indice.sv
// rtl/carregador_matriz_contador_indice.sv - coluna/linha counter pair wrapping at the active size
module contador_indice
  import carregador_matriz_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                clear,
  input  logic                advance,
  input  logic [TAM_BITS-1:0] tam,
  output logic [TAM_BITS-1:0] coluna,
  output logic [TAM_BITS-1:0] linha,
  output logic                ultimo
);

  logic [TAM_BITS-1:0] tam_m1;
  logic                fim_linha;
  logic                fim_coluna;

  assign tam_m1     = tam - TAM_BITS'(1);
  assign fim_linha  = (linha == tam_m1);
  assign fim_coluna = (coluna == tam_m1);
  assign ultimo     = fim_linha && fim_coluna;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      coluna <= '0;
      linha  <= '0;
    end else if (advance) begin
      if (fim_linha) begin
        linha  <= '0;
        coluna <= fim_coluna ? '0 : coluna + TAM_BITS'(1);
      end else begin
        linha <= linha + TAM_BITS'(1);
      end
    end
  end

endmodule

// File: rtl/carregador_matriz.sv
// rtl/carregador_matriz.sv - streams elements into the flat 5x5 matrix bus and hands it off with valid/ack
// Optional CARREGADOR_NEGA_EN: negar latched at inicio stores the two's-complement negation of each element.
module carregador_matriz
  import carregador_matriz_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  carregador_matriz_if.slave  bus
);

  estado_t                 estado;
  logic [TAM_BITS-1:0]     tam_q;
  logic [MATRIZ_BITS-1:0]  matriz_q;
  logic                    elem_pronto_q;
  logic                    matriz_valida_q;
  logic                    ocupado_q;
  logic                    erro_q;
  logic [TAM_BITS-1:0]     coluna;
  logic [TAM_BITS-1:0]     linha;
  logic                    ultimo;
  logic                    partida;
  logic                    transfere;
  logic [LARGURA_ELEM-1:0] elem_escrito;

  assign partida   = (estado == OCIOSO) && bus.inicio && tamanho_legal(bus.tamanho);
  assign transfere = (estado == CARREGA) && bus.elem_valido && elem_pronto_q;

`ifdef CARREGADOR_NEGA_EN
  logic negar_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      negar_q <= 1'b0;
    end else if (partida) begin
      negar_q <= bus.negar;
    end
  end

  // Subtraction from zero wraps, so 0x80 maps onto itself.
  assign elem_escrito = negar_q ? ({LARGURA_ELEM{1'b0}} - bus.elem_dado) : bus.elem_dado;
`else
  assign elem_escrito = bus.elem_dado;
`endif

  contador_indice u_contador (
    .clk     (clk),
    .reset   (reset),
    .clear   (partida),
    .advance (transfere),
    .tam     (tam_q),
    .coluna  (coluna),
    .linha   (linha),
    .ultimo  (ultimo)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      estado          <= OCIOSO;
      tam_q           <= '0;
      matriz_q        <= '0;
      elem_pronto_q   <= 1'b0;
      matriz_valida_q <= 1'b0;
      ocupado_q       <= 1'b0;
      erro_q          <= 1'b0;
    end else begin
      erro_q <= 1'b0;
      case (estado)
        OCIOSO: begin
          if (bus.inicio) begin
            if (partida) begin
              tam_q         <= bus.tamanho;
              matriz_q      <= '0;
              elem_pronto_q <= 1'b1;
              ocupado_q     <= 1'b1;
              estado        <= CARREGA;
            end else begin
              erro_q <= 1'b1;
            end
          end
        end
        CARREGA: begin
          if (transfere) begin
            // Unrolled write-enable decode keeps every part-select base constant.
            for (int c = 0; c < DIM_MAX; c++) begin
              for (int l = 0; l < DIM_MAX; l++) begin
                if (coluna == TAM_BITS'(c) && linha == TAM_BITS'(l)) begin
                  matriz_q[indice(c, l) +: LARGURA_ELEM] <= elem_escrito;
                end
              end
            end
            if (ultimo) begin
              elem_pronto_q   <= 1'b0;
              matriz_valida_q <= 1'b1;
              estado          <= PRONTA;
            end
          end
        end
        PRONTA: begin
          if (bus.matriz_ack) begin
            matriz_valida_q <= 1'b0;
            ocupado_q       <= 1'b0;
            estado          <= OCIOSO;
          end
        end
        default: begin
          estado <= OCIOSO;
        end
      endcase
    end
  end

  assign bus.elem_pronto   = elem_pronto_q;
  assign bus.matriz_saida  = matriz_q;
  assign bus.matriz_valida = matriz_valida_q;
  assign bus.ocupado       = ocupado_q;
  assign bus.erro_tamanho  = erro_q;

endmodule

// File: tb/tb_carregador_matriz.sv
// tb/tb_carregador_matriz.sv - directed self-checking bench for carregador_matriz
module tb_carregador_matriz;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   passed = 0;
  logic [7:0]   dados [25];
  logic [199:0] guardada;

  always #5 clk = ~clk;

  carregador_matriz_if bus ();

  carregador_matriz dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  function automatic logic [7:0] byte_em(input logic [199:0] m, input int c, input int l);
    return m[8*(l+5*c) +: 8];
  endfunction

  task automatic pulso_inicio(input logic [2:0] t);
    bus.inicio  = 1'b1;
    bus.tamanho = t;
    @(negedge clk);
    bus.inicio  = 1'b0;
  endtask

  task automatic carregar(input int n, input bit gaps, output int ciclos, output bit estourou);
    int   i;
    logic v;
    logic aceito;
    i = 0;
    ciclos = 0;
    estourou = 1'b0;
    while (i < n && !estourou) begin
      v = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      bus.elem_valido = v;
      bus.elem_dado   = dados[i];
      aceito = v && bus.elem_pronto;
      @(negedge clk);
      ciclos++;
      if (aceito) i++;
      if (ciclos > 500) estourou = 1'b1;
    end
    bus.elem_valido = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++; if (bus.matriz_saida !== 200'd0) $display("FAIL reset_saida got %0h expected 0", bus.matriz_saida); else passed++;
    checks++; if ({bus.matriz_valida, bus.elem_pronto, bus.ocupado, bus.erro_tamanho} !== 4'b0000)
      $display("FAIL reset_flags got %b expected 0000", {bus.matriz_valida, bus.elem_pronto, bus.ocupado, bus.erro_tamanho});
    else passed++;
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_carga_5x5();
    int ciclos;
    bit estourou;
    for (int k = 0; k < 25; k++) dados[k] = 8'(k + 1);
    pulso_inicio(3'd5);
    checks++; if ({bus.elem_pronto, bus.ocupado, bus.matriz_valida} !== 3'b110)
      $display("FAIL c5_inicio got %b expected 110", {bus.elem_pronto, bus.ocupado, bus.matriz_valida});
    else passed++;
    carregar(25, 1'b0, ciclos, estourou);
    checks++; if (estourou || ciclos !== 25) $display("FAIL c5_ciclos got %0d expected 25", ciclos); else passed++;
    checks++; if ({bus.matriz_valida, bus.elem_pronto} !== 2'b10)
      $display("FAIL c5_valida got %b expected 10", {bus.matriz_valida, bus.elem_pronto});
    else passed++;
    checks++; if (byte_em(bus.matriz_saida, 0, 0) !== 8'd1)  $display("FAIL c5_b00 got %0h expected 1", byte_em(bus.matriz_saida, 0, 0)); else passed++;
    checks++; if (byte_em(bus.matriz_saida, 0, 4) !== 8'd5)  $display("FAIL c5_b04 got %0h expected 5", byte_em(bus.matriz_saida, 0, 4)); else passed++;
    checks++; if (byte_em(bus.matriz_saida, 1, 0) !== 8'd6)  $display("FAIL c5_b10 got %0h expected 6", byte_em(bus.matriz_saida, 1, 0)); else passed++;
    checks++; if (byte_em(bus.matriz_saida, 2, 3) !== 8'd14) $display("FAIL c5_b23 got %0h expected 14", byte_em(bus.matriz_saida, 2, 3)); else passed++;
    checks++; if (byte_em(bus.matriz_saida, 4, 4) !== 8'd25) $display("FAIL c5_b44 got %0h expected 25", byte_em(bus.matriz_saida, 4, 4)); else passed++;
  endtask

  task automatic test_carga_3x3_gaps();
    int ciclos;
    bit estourou;
    logic [7:0] esperado;
    bus.matriz_ack = 1'b1;
    @(negedge clk);
    bus.matriz_ack = 1'b0;
    checks++; if ({bus.matriz_valida, bus.ocupado} !== 2'b00)
      $display("FAIL ack_valida got %b expected 00", {bus.matriz_valida, bus.ocupado});
    else passed++;
    checks++; if (byte_em(bus.matriz_saida, 4, 4) !== 8'd25) $display("FAIL ack_mantem got %0h expected 25", byte_em(bus.matriz_saida, 4, 4)); else passed++;
    for (int k = 0; k < 9; k++) dados[k] = 8'h11 + 8'(k);
    pulso_inicio(3'd3);
    carregar(9, 1'b1, ciclos, estourou);
    checks++; if (estourou || bus.matriz_valida !== 1'b1) $display("FAIL c3_valida got %b expected 1", bus.matriz_valida); else passed++;
    for (int c = 0; c < 5; c++) begin
      for (int l = 0; l < 5; l++) begin
        esperado = (c < 3 && l < 3) ? 8'h11 + 8'(3*c + l) : 8'h00;
        checks++;
        if (byte_em(bus.matriz_saida, c, l) !== esperado)
          $display("FAIL c3_byte(%0d,%0d) got %0h expected %0h", c, l, byte_em(bus.matriz_saida, c, l), esperado);
        else passed++;
      end
    end
    bus.matriz_ack = 1'b1;
    @(negedge clk);
    bus.matriz_ack = 1'b0;
  endtask

  task automatic test_tamanho_ilegal();
    guardada = bus.matriz_saida;
    pulso_inicio(3'd6);
    checks++; if ({bus.erro_tamanho, bus.ocupado, bus.elem_pronto} !== 3'b100)
      $display("FAIL ilegal_pulso got %b expected 100", {bus.erro_tamanho, bus.ocupado, bus.elem_pronto});
    else passed++;
    @(negedge clk);
    checks++; if ({bus.erro_tamanho, bus.ocupado} !== 2'b00)
      $display("FAIL ilegal_um_ciclo got %b expected 00", {bus.erro_tamanho, bus.ocupado});
    else passed++;
    checks++; if (bus.matriz_saida !== guardada) $display("FAIL ilegal_saida got %0h expected %0h", bus.matriz_saida, guardada); else passed++;
  endtask

  task automatic test_reset_meio();
    int ciclos;
    bit estourou;
    for (int k = 0; k < 25; k++) dados[k] = 8'h40 + 8'(k);
    pulso_inicio(3'd5);
    carregar(10, 1'b0, ciclos, estourou);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++; if (bus.matriz_saida !== 200'd0) $display("FAIL rst_meio_saida got %0h expected 0", bus.matriz_saida); else passed++;
    checks++; if ({bus.ocupado, bus.elem_pronto, bus.matriz_valida} !== 3'b000)
      $display("FAIL rst_meio_flags got %b expected 000", {bus.ocupado, bus.elem_pronto, bus.matriz_valida});
    else passed++;
    for (int k = 0; k < 4; k++) dados[k] = 8'hA1 + 8'(k);
    pulso_inicio(3'd2);
    carregar(4, 1'b0, ciclos, estourou);
    checks++; if (estourou || ciclos !== 4 || bus.matriz_valida !== 1'b1)
      $display("FAIL c2_valida got %b after %0d cycles expected 1 after 4", bus.matriz_valida, ciclos);
    else passed++;
    checks++; if ({byte_em(bus.matriz_saida, 0, 0), byte_em(bus.matriz_saida, 0, 1), byte_em(bus.matriz_saida, 1, 0), byte_em(bus.matriz_saida, 1, 1)} !== 32'hA1A2A3A4)
      $display("FAIL c2_bytes got %0h expected a1a2a3a4",
               {byte_em(bus.matriz_saida, 0, 0), byte_em(bus.matriz_saida, 0, 1), byte_em(bus.matriz_saida, 1, 0), byte_em(bus.matriz_saida, 1, 1)});
    else passed++;
    checks++; if (byte_em(bus.matriz_saida, 0, 2) !== 8'h00) $display("FAIL c2_pad got %0h expected 0", byte_em(bus.matriz_saida, 0, 2)); else passed++;
  endtask

  task automatic test_pronta_espera();
    int ruins_pronto;
    int ruins_valida;
    int ruins_saida;
    ruins_pronto = 0;
    ruins_valida = 0;
    ruins_saida  = 0;
    guardada = bus.matriz_saida;
    for (int i = 0; i < 20; i++) begin
      bus.elem_valido = 1'b1;
      bus.elem_dado   = 8'hEE;
      bus.inicio      = (i == 5);
      bus.tamanho     = 3'd3;
      @(negedge clk);
      if (bus.elem_pronto !== 1'b0) ruins_pronto++;
      if (bus.matriz_valida !== 1'b1 || bus.ocupado !== 1'b1) ruins_valida++;
      if (bus.matriz_saida !== guardada) ruins_saida++;
    end
    bus.inicio = 1'b0;
    bus.elem_valido = 1'b0;
    checks++; if (ruins_pronto !== 0) $display("FAIL pronta_pronto got %0d bad cycles expected 0", ruins_pronto); else passed++;
    checks++; if (ruins_valida !== 0) $display("FAIL pronta_valida got %0d bad cycles expected 0", ruins_valida); else passed++;
    checks++; if (ruins_saida !== 0) $display("FAIL pronta_saida got %0d bad cycles expected 0", ruins_saida); else passed++;
    bus.matriz_ack = 1'b1;
    @(negedge clk);
    bus.matriz_ack = 1'b0;
    checks++; if ({bus.matriz_valida, bus.ocupado} !== 2'b00)
      $display("FAIL pronta_ack got %b expected 00", {bus.matriz_valida, bus.ocupado});
    else passed++;
    checks++; if (bus.matriz_saida !== guardada) $display("FAIL pronta_ack_saida got %0h expected %0h", bus.matriz_saida, guardada); else passed++;
  endtask

`ifdef CARREGADOR_NEGA_EN
  task automatic test_nega();
    int ciclos;
    bit estourou;
    dados[0] = 8'h01;
    dados[1] = 8'h80;
    dados[2] = 8'h00;
    dados[3] = 8'h7F;
    bus.negar = 1'b1;
    pulso_inicio(3'd2);
    bus.negar = 1'b0;
    carregar(4, 1'b0, ciclos, estourou);
    checks++; if (estourou || bus.matriz_valida !== 1'b1) $display("FAIL nega_valida got %b expected 1", bus.matriz_valida); else passed++;
    checks++; if ({byte_em(bus.matriz_saida, 0, 0), byte_em(bus.matriz_saida, 0, 1), byte_em(bus.matriz_saida, 1, 0), byte_em(bus.matriz_saida, 1, 1)} !== 32'hFF800081)
      $display("FAIL nega_bytes got %0h expected ff800081",
               {byte_em(bus.matriz_saida, 0, 0), byte_em(bus.matriz_saida, 0, 1), byte_em(bus.matriz_saida, 1, 0), byte_em(bus.matriz_saida, 1, 1)});
    else passed++;
    checks++; if (byte_em(bus.matriz_saida, 2, 2) !== 8'h00) $display("FAIL nega_pad got %0h expected 0", byte_em(bus.matriz_saida, 2, 2)); else passed++;
    bus.matriz_ack = 1'b1;
    @(negedge clk);
    bus.matriz_ack = 1'b0;
  endtask
`endif

  initial begin
    reset           = 1'b1;
    bus.inicio      = 1'b0;
    bus.tamanho     = 3'd0;
    bus.elem_dado   = 8'd0;
    bus.elem_valido = 1'b0;
    bus.matriz_ack  = 1'b0;
`ifdef CARREGADOR_NEGA_EN
    bus.negar       = 1'b0;
`endif
    for (int k = 0; k < 25; k++) dados[k] = 8'd0;
    @(negedge clk);
    test_reset();
    test_carga_5x5();
    test_carga_3x3_gaps();
    test_tamanho_ilegal();
    test_reset_meio();
    test_pronta_espera();
`ifdef CARREGADOR_NEGA_EN
    test_nega();
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
